// File: rtl/vcr_pkg.sv
// Shared types for the vector condition register: read condition codes,
// per-lane compare flags and the lane-count helper.
package Vcr_pkg;

    typedef enum logic [1:0] {
        VCR_ALWAYS = 2'b00,
        VCR_GT     = 2'b01,
        VCR_LT     = 2'b10,
        VCR_EQ     = 2'b11
    } Vcr_cond;

    // Matches the vcr_in lane layout {gt,lt} at [2i+1:2i].
    typedef struct packed {
        logic gt;
        logic lt;
    } Vcr_flags;

    function automatic int vcr_lanes(input int num_elems);
        return 2 * num_elems;
    endfunction

endpackage

// File: rtl/vcr_mask_gen.sv
// Combinational byte-lane mask from per-lane {gt,lt} flags and a condition code.
// A lane with both flags set reads as greater-than only.
module vcr_mask_gen
    import Vcr_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic [2*LANES-1:0] flags,
    input  logic [1:0]         cond,
    output logic [LANES-1:0]   mask
);

    Vcr_flags f;

    always_comb begin
        mask = '0;
        f    = '0;
        for (int i = 0; i < LANES; i++) begin
            f = Vcr_flags'(flags[2*i +: 2]);
            case (Vcr_cond'(cond))
                VCR_ALWAYS: mask[i] = 1'b1;
                VCR_GT:     mask[i] = f.gt;
                VCR_LT:     mask[i] = f.lt & ~f.gt;
                VCR_EQ:     mask[i] = ~f.gt & ~f.lt;
                default:    mask[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/vector_cond_reg.sv
// Vector condition register: captures compare flags, tracks compares in flight,
// and answers conditional reads with a registered byte-lane mask one cycle later.
module vector_cond_reg
    import Vcr_pkg::*;
#(
    parameter  int NUM_ELEMS   = 8,
    parameter  int ELEM_SIZE   = 16,
    parameter  int MAX_PENDING = 2,
    localparam int LANES       = vcr_lanes(NUM_ELEMS),
    localparam int CNTW        = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmp_issue,
    input  logic                 write_vcr,
    input  logic [2*LANES-1:0]   vcr_in,
    input  logic                 rd_valid,
    input  logic [1:0]           rd_cond,
    output logic                 rd_ready,
    output logic                 mask_valid,
    output logic [LANES-1:0]     mask,
    output logic [CNTW-1:0]      pending,
    output logic                 err
);

    localparam logic [CNTW-1:0] PEND_MAX = CNTW'(MAX_PENDING);
    localparam logic [CNTW-1:0] PEND_ONE = CNTW'(1);

    // Byte lanes are half an element; only 16-bit elements are supported.
    if (ELEM_SIZE != 16) begin : g_elem_size_check
        $error("vector_cond_reg: ELEM_SIZE must be 16");
    end

    logic [2*LANES-1:0] vcr;
    logic [2*LANES-1:0] mask_src;
    logic [LANES-1:0]   mask_next;
    logic               accept;
    logic               inc;
    logic               dec;

    // A same-cycle issue is older than the read, so it always stalls the read.
    assign rd_ready = ~cmp_issue &
                      ((pending == '0) | ((pending == PEND_ONE) & write_vcr));
    assign accept   = rd_valid & rd_ready;
    assign inc      = cmp_issue & ~write_vcr;
    assign dec      = write_vcr & ~cmp_issue;
    assign mask_src = write_vcr ? vcr_in : vcr;

    vcr_mask_gen #(
        .LANES (LANES)
    ) u_mask_gen (
        .flags (mask_src),
        .cond  (rd_cond),
        .mask  (mask_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            err     <= 1'b0;
        end else if (inc) begin
            if (pending == PEND_MAX) begin
                err <= 1'b1;
            end else begin
                pending <= pending + PEND_ONE;
            end
        end else if (dec) begin
            if (pending == '0) begin
                err <= 1'b1;
            end else begin
                pending <= pending - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vcr <= '0;
        end else if (write_vcr) begin
            vcr <= vcr_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_valid <= 1'b0;
            mask       <= '0;
        end else begin
            mask_valid <= accept;
            if (accept) begin
                mask <= mask_next;
            end
        end
    end

endmodule

// File: tb/tb_vector_cond_reg.sv
// Directed bench for vector_cond_reg with hand-computed masks, pending counts and error flags.
module tb_vector_cond_reg;

    logic        clk;
    logic        reset;
    logic        cmp_issue;
    logic        write_vcr;
    logic [31:0] vcr_in;
    logic        rd_valid;
    logic [1:0]  rd_cond;
    logic        rd_ready;
    logic        mask_valid;
    logic [15:0] mask;
    logic [1:0]  pending;
    logic        err;

    int total;
    int bad;

    localparam logic [1:0] C_ALW = 2'b00;
    localparam logic [1:0] C_GT  = 2'b01;
    localparam logic [1:0] C_LT  = 2'b10;
    localparam logic [1:0] C_EQ  = 2'b11;

    vector_cond_reg #(
        .NUM_ELEMS   (8),
        .ELEM_SIZE   (16),
        .MAX_PENDING (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmp_issue  (cmp_issue),
        .write_vcr  (write_vcr),
        .vcr_in     (vcr_in),
        .rd_valid   (rd_valid),
        .rd_cond    (rd_cond),
        .rd_ready   (rd_ready),
        .mask_valid (mask_valid),
        .mask       (mask),
        .pending    (pending),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cmp_issue = 1'b0;
        write_vcr = 1'b0;
        vcr_in    = '0;
        rd_valid  = 1'b0;
        rd_cond   = C_ALW;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_mask_valid", {31'b0, mask_valid}, 32'd0);
        chk("rst_mask", {16'b0, mask}, 32'd0);
        chk("rst_pending", {30'b0, pending}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;

        // 1: eq read straight after reset, vcr is all-eq
        rd_valid = 1'b1; rd_cond = C_EQ;
        #1 chk("t1_ready", {31'b0, rd_ready}, 32'd1);
        tick();
        rd_valid = 1'b0;
        chk("t1_valid", {31'b0, mask_valid}, 32'd1);
        chk("t1_mask", {16'b0, mask}, 32'h0000_FFFF);
        tick();
        chk("t1_pulse_end", {31'b0, mask_valid}, 32'd0);
        chk("t1_mask_hold", {16'b0, mask}, 32'h0000_FFFF);

        // 2: issue, write 5555_5555 (all lt), then lt and gt reads back to back
        cmp_issue = 1'b1;
        tick();
        cmp_issue = 1'b0;
        chk("t2_pend1", {30'b0, pending}, 32'd1);
        write_vcr = 1'b1; vcr_in = 32'h5555_5555;
        tick();
        idle();
        chk("t2_pend0", {30'b0, pending}, 32'd0);
        rd_valid = 1'b1; rd_cond = C_LT;
        #1 chk("t2_ready", {31'b0, rd_ready}, 32'd1);
        tick();
        rd_cond = C_GT;
        chk("t2_lt_valid", {31'b0, mask_valid}, 32'd1);
        chk("t2_lt_mask", {16'b0, mask}, 32'h0000_FFFF);
        tick();
        rd_valid = 1'b0;
        chk("t2_gt_valid", {31'b0, mask_valid}, 32'd1);
        chk("t2_gt_mask", {16'b0, mask}, 32'h0000_0000);
        tick();
        chk("t2_idle_valid", {31'b0, mask_valid}, 32'd0);

        // 3: read stalls behind an issue, then bypasses the write data
        cmp_issue = 1'b1;
        rd_valid = 1'b1; rd_cond = C_GT;
        #1 chk("t3_ready_issue", {31'b0, rd_ready}, 32'd0);
        tick();
        cmp_issue = 1'b0;
        #1 chk("t3_ready_stall", {31'b0, rd_ready}, 32'd0);
        tick();
        chk("t3_stall_no_pulse", {31'b0, mask_valid}, 32'd0);
        write_vcr = 1'b1; vcr_in = 32'hAAAA_0000;
        #1 chk("t3_ready_bypass", {31'b0, rd_ready}, 32'd1);
        tick();
        idle();
        chk("t3_valid", {31'b0, mask_valid}, 32'd1);
        chk("t3_mask", {16'b0, mask}, 32'h0000_FF00);
        chk("t3_pend", {30'b0, pending}, 32'd0);

        // 4: two compares in flight; accept only with the second write
        cmp_issue = 1'b1;
        tick();
        tick();
        cmp_issue = 1'b0;
        chk("t4_pend2", {30'b0, pending}, 32'd2);
        write_vcr = 1'b1; vcr_in = 32'h5555_5555;
        rd_valid = 1'b1; rd_cond = C_EQ;
        #1 chk("t4_ready_pend2", {31'b0, rd_ready}, 32'd0);
        tick();
        chk("t4_pend1", {30'b0, pending}, 32'd1);
        chk("t4_no_pulse", {31'b0, mask_valid}, 32'd0);
        vcr_in = 32'h0000_5555;
        #1 chk("t4_ready_last", {31'b0, rd_ready}, 32'd1);
        tick();
        idle();
        chk("t4_valid", {31'b0, mask_valid}, 32'd1);
        chk("t4_mask", {16'b0, mask}, 32'h0000_FF00);
        chk("t4_pend0", {30'b0, pending}, 32'd0);
        chk("t4_err", {31'b0, err}, 32'd0);

        // both flags set in every lane reads as gt, never eq
        cmp_issue = 1'b1;
        tick();
        cmp_issue = 1'b0;
        write_vcr = 1'b1; vcr_in = 32'hFFFF_FFFF;
        rd_valid = 1'b1; rd_cond = C_GT;
        tick();
        write_vcr = 1'b0;
        rd_cond = C_EQ;
        chk("both_gt", {16'b0, mask}, 32'h0000_FFFF);
        tick();
        idle();
        chk("both_eq", {16'b0, mask}, 32'h0000_0000);
        chk("both_err", {31'b0, err}, 32'd0);

        // 5: write with nothing pending, then issue overflow
        write_vcr = 1'b1; vcr_in = 32'h0000_AAAA;
        tick();
        idle();
        chk("t5_err_underflow", {31'b0, err}, 32'd1);
        chk("t5_pend0", {30'b0, pending}, 32'd0);
        rd_valid = 1'b1; rd_cond = C_GT;
        tick();
        rd_valid = 1'b0;
        chk("t5_vcr_written", {16'b0, mask}, 32'h0000_00FF);
        cmp_issue = 1'b1;
        tick();
        tick();
        tick();
        cmp_issue = 1'b0;
        chk("t5_pend_sat", {30'b0, pending}, 32'd2);
        chk("t5_err_sticky", {31'b0, err}, 32'd1);

        // 6: reset clears counter and error; reset during the mask pulse kills it
        reset = 1'b1;
        #1;
        chk("t6_pend_rst", {30'b0, pending}, 32'd0);
        chk("t6_err_rst", {31'b0, err}, 32'd0);
        tick();
        reset = 1'b0;
        cmp_issue = 1'b1;
        tick();
        cmp_issue = 1'b0;
        write_vcr = 1'b1; vcr_in = 32'h5555_5555;
        tick();
        idle();
        rd_valid = 1'b1; rd_cond = C_EQ;
        tick();
        rd_valid = 1'b0;
        chk("t6_pulse_before_rst", {31'b0, mask_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_valid_killed", {31'b0, mask_valid}, 32'd0);
        chk("t6_mask_cleared", {16'b0, mask}, 32'd0);
        tick();
        reset = 1'b0;
        chk("t6_no_late_pulse", {31'b0, mask_valid}, 32'd0);
        rd_valid = 1'b1; rd_cond = C_EQ;
        tick();
        rd_valid = 1'b0;
        chk("t6_eq_after_rst", {16'b0, mask}, 32'h0000_FFFF);
        chk("t6_valid_after_rst", {31'b0, mask_valid}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
